// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and the instruction-fetch state encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_HI = 2'd1,
        FETCH_LO = 2'd2,
        HOLD     = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Two-byte instruction fetch from a byte-wide shared memory; steers the PC
// through next_address and holds the assembled instruction for decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
    parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  current_address,
    output logic [ADDR_W-1:0]  next_address,
    input  logic               fetch_en,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [7:0]         mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_accept,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic [ADDR_W-1:0]  w_addr_inc;

    assign w_addr_inc  = current_address + ADDR_W'(1);
    assign instr       = r_instr;
    assign instr_valid = r_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == FETCH_HI && mem_ack) begin
                r_instr[INSTR_W-1 -: 8] <= mem_rdata;
            end
            if (r_state == FETCH_LO && mem_ack) begin
                r_instr[7:0] <= mem_rdata;
                r_valid      <= 1'b1;
            end
            if (r_state == HOLD && instr_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (fetch_en)     w_state_next = FETCH_HI;
            FETCH_HI: if (mem_ack)      w_state_next = FETCH_LO;
            FETCH_LO: if (mem_ack)      w_state_next = HOLD;
            HOLD:     if (instr_accept) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // The PC advances only on a byte ack or a taken branch; otherwise it holds.
    always_comb begin
        mem_req      = 1'b0;
        mem_addr     = '0;
        next_address = current_address;
        case (r_state)
            FETCH_HI, FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = current_address;
                if (mem_ack) begin
                    next_address = w_addr_inc;
                end
            end
            HOLD: begin
                if (instr_accept && branch_taken) begin
                    next_address = branch_target;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bench owns the PC register fed by next_address.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pc;
    logic [7:0]  next_address;
    logic        fetch_en;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_accept;
    logic        branch_taken;
    logic [7:0]  branch_target;

    logic        pc_wr;
    logic [7:0]  pc_wdata;
    int          vectors;
    int          miscompares;
    int          cyc;
    int          cyc0;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clock           (clk),
        .reset           (rst_n),
        .current_address (pc),
        .next_address    (next_address),
        .fetch_en        (fetch_en),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_accept    (instr_accept),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pc <= pc_wr ? pc_wdata : next_address;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_pc(input logic [7:0] v);
        pc_wr    = 1'b1;
        pc_wdata = v;
        step();
        pc_wr    = 1'b0;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; cyc0 = 0;
        rst_n = 1'b0; fetch_en = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        instr_accept = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        pc_wr = 1'b1; pc_wdata = 8'h10;

        // reset state
        #3;
        chk1 ("rst_valid", instr_valid, 1'b0);
        chk16("rst_instr", instr, 16'h0000);
        chk1 ("rst_req", mem_req, 1'b0);
        chk8 ("rst_addr", mem_addr, 8'h00);
        step();
        chk8 ("rst_next", next_address, 8'h10);
        pc_wr = 1'b0;
        rst_n = 1'b1;

        // zero-wait fetch at 0x10: AB, CD
        fetch_en = 1'b1; #1;
        chk1 ("idle_req", mem_req, 1'b0);
        cyc0 = cyc;
        step();
        fetch_en = 1'b0;
        chk1 ("hi_req", mem_req, 1'b1);
        chk8 ("hi_addr", mem_addr, 8'h10);
        chk8 ("hi_next_noack", next_address, 8'h10);
        mem_ack = 1'b1; mem_rdata = 8'hAB; #1;
        chk8 ("hi_next_ack", next_address, 8'h11);
        step();
        mem_rdata = 8'hCD; #1;
        chk8 ("pc_11", pc, 8'h11);
        chk8 ("lo_addr", mem_addr, 8'h11);
        chk8 ("lo_next_ack", next_address, 8'h12);
        step();
        mem_ack = 1'b0; #1;
        chk_int("lat_zero_wait", cyc - cyc0, 3);
        chk8 ("pc_12", pc, 8'h12);
        chk1 ("hold_valid", instr_valid, 1'b1);
        chk16("instr_ABCD", instr, 16'hABCD);
        chk1 ("hold_req", mem_req, 1'b0);
        instr_accept = 1'b1; #1;
        chk8 ("accept_next", next_address, 8'h12);
        step();
        instr_accept = 1'b0; #1;
        chk1 ("accept_clears", instr_valid, 1'b0);
        chk8 ("pc_after_acc", pc, 8'h12);

        // address wrap between bytes at 0xFF
        set_pc(8'hFF);
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        chk8 ("wrap_hi_addr", mem_addr, 8'hFF);
        mem_ack = 1'b1; mem_rdata = 8'h12; #1;
        chk8 ("wrap_next", next_address, 8'h00);
        step();
        mem_rdata = 8'h34; #1;
        chk8 ("wrap_lo_addr", mem_addr, 8'h00);
        chk8 ("wrap_lo_next", next_address, 8'h01);
        step();
        mem_ack = 1'b0; #1;
        chk16("instr_1234", instr, 16'h1234);
        instr_accept = 1'b1;
        step();
        instr_accept = 1'b0; #1;
        chk8 ("wrap_pc_end", pc, 8'h01);

        // three wait cycles per byte
        set_pc(8'h20);
        fetch_en = 1'b1;
        cyc0 = cyc;
        step();
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1 ("wait_hi_req", mem_req, 1'b1);
            chk8 ("wait_hi_addr", mem_addr, 8'h20);
            chk8 ("wait_hi_next", next_address, 8'h20);
            step();
        end
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk8 ("wait_lo_addr", mem_addr, 8'h21);
            chk8 ("wait_lo_next", next_address, 8'h21);
            chk1 ("wait_lo_valid", instr_valid, 1'b0);
            step();
        end
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        step();
        mem_ack = 1'b0; #1;
        chk_int("lat_wait3", cyc - cyc0, 9);
        chk1 ("wait_valid", instr_valid, 1'b1);
        chk16("instr_5AA5", instr, 16'h5AA5);
        chk8 ("wait_pc", pc, 8'h22);

        // branch without accept ignored, then taken branch to 0x40
        branch_taken = 1'b1; branch_target = 8'h40; #1;
        chk8 ("br_no_accept", next_address, 8'h22);
        step();
        chk1 ("br_still_valid", instr_valid, 1'b1);
        instr_accept = 1'b1; #1;
        chk8 ("br_next", next_address, 8'h40);
        step();
        instr_accept = 1'b0; branch_taken = 1'b0;
        chk8 ("br_pc", pc, 8'h40);
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        chk8 ("br_fetch_addr", mem_addr, 8'h40);

        // reset between the two acks, then a stray ack
        mem_ack = 1'b1; mem_rdata = 8'h77;
        step();
        mem_ack = 1'b0;
        rst_n = 1'b0; #1;
        chk1 ("mid_rst_valid", instr_valid, 1'b0);
        chk16("mid_rst_instr", instr, 16'h0000);
        chk1 ("mid_rst_req", mem_req, 1'b0);
        chk8 ("mid_rst_addr", mem_addr, 8'h00);
        chk8 ("mid_rst_next", next_address, 8'h41);
        rst_n = 1'b1; #1;
        mem_ack = 1'b1; mem_rdata = 8'h99; #1;
        chk8 ("stray_next", next_address, 8'h41);
        step();
        mem_ack = 1'b0; #1;
        chk1 ("stray_valid", instr_valid, 1'b0);
        chk16("stray_instr", instr, 16'h0000);
        chk1 ("stray_req", mem_req, 1'b0);
        chk8 ("stray_pc", pc, 8'h41);

        // accept without valid, then fetch_en dropped during FETCH_LO
        instr_accept = 1'b1; branch_taken = 1'b1; branch_target = 8'h80; #1;
        chk8 ("acc_novalid_next", next_address, 8'h41);
        step();
        instr_accept = 1'b0; branch_taken = 1'b0;
        chk8 ("acc_novalid_pc", pc, 8'h41);
        chk1 ("acc_novalid_req", mem_req, 1'b0);
        fetch_en = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 8'h11;
        step();
        fetch_en = 1'b0; mem_rdata = 8'h22; #1;
        chk1 ("fe_drop_req", mem_req, 1'b1);
        chk8 ("fe_drop_addr", mem_addr, 8'h42);
        step();
        mem_ack = 1'b0; #1;
        chk1 ("fe_drop_valid", instr_valid, 1'b1);
        chk16("instr_1122", instr, 16'h1122);
        instr_accept = 1'b1;
        step();
        instr_accept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1 ("fe_low_req", mem_req, 1'b0);
            chk8 ("fe_low_next", next_address, 8'h43);
            step();
        end
        chk8 ("fe_low_pc", pc, 8'h43);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
